pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage core.
- Drives the enable inputs of PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Drives per-stage flush (bubble-insert) strobes.
- Resolves load-use hazards, taken-branch redirects and instruction/data memory wait handshakes.
- Guards memory waits with a timeout that halts the core and flags a bus error.

---
 rtl/core_ctrl_pkg.sv | 56 +++++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Purpose : shared state encoding, register constants and stage-control bundle for core control.
// Latency : none (types and constants only).
// Backpressure: none.
//
// Contents:
//   ctrl_state_e  - hazard controller FSM states
//   REG_X0        - hard-wired zero register index (never a real dependency)
//   stage_ctrl_t  - PC enable plus enable/flush for every pipeline register
//   CTRL_*        - canned stage-control patterns used by the controller
package core_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      DMEM_WAIT = 2'd1,
      IMEM_WAIT = 2'd2,
      HALT      = 2'd3
   } ctrl_state_e;

   localparam logic [4:0] REG_X0 = 5'd0;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic ifid_flush;
      logic idex_en;
      logic idex_flush;
      logic exmem_en;
      logic memwb_en;
   } stage_ctrl_t;

   // Everything frozen, nothing flushed: reset, halt and data-memory wait.
   localparam stage_ctrl_t CTRL_OFF = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                        idex_en: 1'b0, idex_flush: 1'b0,
                                        exmem_en: 1'b0, memwb_en: 1'b0};

   // Free flow.
   localparam stage_ctrl_t CTRL_FLOW = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                         idex_en: 1'b1, idex_flush: 1'b0,
                                         exmem_en: 1'b1, memwb_en: 1'b1};

   // Taken branch: fetch the target, squash the two wrong-path instructions.
   localparam stage_ctrl_t CTRL_BRANCH = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1,
                                           idex_en: 1'b1, idex_flush: 1'b1,
                                           exmem_en: 1'b1, memwb_en: 1'b1};

   // Load-use: hold PC and ID, send one bubble into EX while the load moves on.
   localparam stage_ctrl_t CTRL_LOAD_USE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                             idex_en: 1'b1, idex_flush: 1'b1,
                                             exmem_en: 1'b1, memwb_en: 1'b1};

   // Fetch not back yet: hold PC, feed a bubble into ID, drain the rest.
   localparam stage_ctrl_t CTRL_IMEM_WAIT = '{pc_en: 1'b0, ifid_en: 1'b1, ifid_flush: 1'b1,
                                              idex_en: 1'b1, idex_flush: 1'b0,
                                              exmem_en: 1'b1, memwb_en: 1'b1};

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Purpose : load-use dependency compare between the load in EX and the instruction in ID.
// Latency : combinational.
// Backpressure: none; pure function of its inputs.
//
// Ports: idex_mem_read/idex_rd describe the EX instruction, ifid_rs1/ifid_rs2 the ID
// sources; load_use is high when ID needs a value the EX load has not produced yet.
module hazard_detect
   import core_ctrl_pkg::*;
(
   input  logic       idex_mem_read,
   input  logic [4:0] idex_rd,
   input  logic [4:0] ifid_rs1,
   input  logic [4:0] ifid_rs2,
   output logic       load_use
);

   always_comb begin
      load_use = idex_mem_read && (idex_rd != REG_X0) &&
                 ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose : central stall/flush controller for the 5-stage core, with memory-wait timeout.
// Latency : stage controls are combinational (same cycle); state, flags and counter update at clk.
// Backpressure: memory not-ready freezes/bubbles the pipeline; a timed-out wait halts until reset.
//
// Ports:
//   clk, rst (synchronous, active-low)
//   idex_mem_read, idex_rd, ifid_rs1, ifid_rs2 - load-use detection inputs
//   ex_branch_taken                            - redirect from EX
//   exmem_mem_access, dmem_ready, imem_ready   - memory wait handshakes
//   pc_en, *_en, *_flush                       - stage controls
//   halted, bus_error                          - sticky timeout status
//   stall_count                                - saturating count of stalled, non-halted cycles
module pipeline_hazard_ctrl #(
   parameter int TIMEOUT     = 16,
   parameter int STALL_CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   idex_mem_read,
   input  logic [4:0]             idex_rd,
   input  logic [4:0]             ifid_rs1,
   input  logic [4:0]             ifid_rs2,
   input  logic                   ex_branch_taken,
   input  logic                   exmem_mem_access,
   input  logic                   dmem_ready,
   input  logic                   imem_ready,
   output logic                   pc_en,
   output logic                   ifid_en,
   output logic                   ifid_flush,
   output logic                   idex_en,
   output logic                   idex_flush,
   output logic                   exmem_en,
   output logic                   memwb_en,
   output logic                   halted,
   output logic                   bus_error,
   output logic [STALL_CNT_W-1:0] stall_count
);

   import core_ctrl_pkg::*;

   // At least one bit so the counter stays legal when the timeout is disabled.
   localparam int WCNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WCNT_W-1:0]      WCNT_LIMIT = WCNT_W'(TIMEOUT);
   localparam logic [WCNT_W-1:0]      WCNT_MAX   = '1;
   localparam logic [WCNT_W-1:0]      WCNT_ONE   = WCNT_W'(1);
   localparam logic [STALL_CNT_W-1:0] STALL_MAX  = '1;

   ctrl_state_e             state_q, state_d;
   logic [WCNT_W-1:0]       wait_cnt_q, wait_cnt_d;
   logic                    halted_q, halted_d;
   logic                    bus_error_q, bus_error_d;
   logic [STALL_CNT_W-1:0]  stall_count_q, stall_count_d;

   logic                    load_use;
   logic                    dmem_wait;
   logic                    timed_out;
   logic [WCNT_W-1:0]       wait_cnt_inc;
   stage_ctrl_t             run_ctrl;
   ctrl_state_e             run_next;
   logic [WCNT_W-1:0]       run_cnt;
   stage_ctrl_t             ctrl;

   hazard_detect u_hazard_detect (
      .idex_mem_read (idex_mem_read),
      .idex_rd       (idex_rd),
      .ifid_rs1      (ifid_rs1),
      .ifid_rs2      (ifid_rs2),
      .load_use      (load_use)
   );

   // Decision the RUN state would make this cycle; the wait states reuse it when
   // their own condition no longer holds.
   always_comb begin
      dmem_wait = exmem_mem_access && !dmem_ready;
      run_ctrl  = CTRL_FLOW;
      run_next  = RUN;
      run_cnt   = '0;
      if (dmem_wait) begin
         // EX is frozen too, so a pending branch or load-use is seen again afterwards.
         run_ctrl = CTRL_OFF;
         run_next = DMEM_WAIT;
         run_cnt  = WCNT_ONE;
      end else if (ex_branch_taken) begin
         run_ctrl = CTRL_BRANCH;
      end else if (load_use) begin
         run_ctrl = CTRL_LOAD_USE;
      end else if (!imem_ready) begin
         run_ctrl = CTRL_IMEM_WAIT;
         run_next = IMEM_WAIT;
         run_cnt  = WCNT_ONE;
      end
   end

   always_comb begin
      timed_out    = (TIMEOUT != 0) && (wait_cnt_q == WCNT_LIMIT);
      wait_cnt_inc = (wait_cnt_q == WCNT_MAX) ? wait_cnt_q : wait_cnt_q + WCNT_ONE;

      ctrl          = CTRL_OFF;
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      halted_d      = halted_q;
      bus_error_d   = bus_error_q;
      stall_count_d = stall_count_q;

      if (!rst) begin
         state_d       = RUN;
         wait_cnt_d    = '0;
         halted_d      = 1'b0;
         bus_error_d   = 1'b0;
         stall_count_d = '0;
      end else begin
         unique case (state_q)
            RUN: begin
               ctrl       = run_ctrl;
               state_d    = run_next;
               wait_cnt_d = run_cnt;
            end
            DMEM_WAIT: begin
               if (dmem_ready) begin
                  ctrl       = run_ctrl;
                  state_d    = RUN;
                  wait_cnt_d = '0;
               end else if (timed_out) begin
                  state_d     = HALT;
                  halted_d    = 1'b1;
                  bus_error_d = 1'b1;
               end else begin
                  wait_cnt_d = wait_cnt_inc;
               end
            end
            IMEM_WAIT: begin
               ctrl = run_ctrl;
               if (dmem_wait) begin
                  state_d    = DMEM_WAIT;
                  wait_cnt_d = WCNT_ONE;
               end else if (ex_branch_taken || imem_ready) begin
                  state_d    = RUN;
                  wait_cnt_d = '0;
               end else if (timed_out) begin
                  state_d     = HALT;
                  halted_d    = 1'b1;
                  bus_error_d = 1'b1;
               end else begin
                  wait_cnt_d = wait_cnt_inc;
               end
            end
            default: begin
               ctrl = CTRL_OFF;
            end
         endcase

         if ((state_q != HALT) && !ctrl.pc_en && (stall_count_q != STALL_MAX)) begin
            stall_count_d = stall_count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      halted_q      <= halted_d;
      bus_error_q   <= bus_error_d;
      stall_count_q <= stall_count_d;
   end

   assign pc_en       = ctrl.pc_en;
   assign ifid_en     = ctrl.ifid_en;
   assign ifid_flush  = ctrl.ifid_flush;
   assign idex_en     = ctrl.idex_en;
   assign idex_flush  = ctrl.idex_flush;
   assign exmem_en    = ctrl.exmem_en;
   assign memwb_en    = ctrl.memwb_en;
   assign halted      = halted_q;
   assign bus_error   = bus_error_q;
   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Purpose : self-checking bench for pipeline_hazard_ctrl (vector table, corner sequences, random vs model).
// Latency : checks comb outputs 1ns after inputs change at negedge; registered values reflect prior edges.
// Backpressure: n/a.
module tb_pipeline_hazard_ctrl;
   import core_ctrl_pkg::*;

   typedef struct {
      logic       rst;
      logic       mr;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       br;
      logic       ma;
      logic       dr;
      logic       ir;
   } vin_t;

   typedef struct {
      vin_t       i;
      logic [6:0] exp_ctl;   // {pc, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
      int         exp_stall;
   } vec_t;

   // Reference model state, kept in its own terms.
   typedef struct {
      int     phase;   // 0 flowing, 1 waiting on data, 2 waiting on fetch, 3 stopped
      int     waited;
      bit     halted;
      bit     berr;
      longint stalls;
   } mdl_t;

   localparam logic [6:0] E_OFF  = 7'b0000000;
   localparam logic [6:0] E_FLOW = 7'b1101011;
   localparam logic [6:0] E_BR   = 7'b1111111;
   localparam logic [6:0] E_LU   = 7'b0001111;
   localparam logic [6:0] E_IM   = 7'b0111011;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic idex_mem_read = 1'b0, ex_branch_taken = 1'b0, exmem_mem_access = 1'b0;
   logic dmem_ready = 1'b1, imem_ready = 1'b1;
   logic [4:0] idex_rd = '0, ifid_rs1 = '0, ifid_rs2 = '0;

   logic pc_en_a, ifid_en_a, ifid_flush_a, idex_en_a, idex_flush_a, exmem_en_a, memwb_en_a;
   logic halted_a, bus_error_a;
   logic [31:0] stall_count_a;
   logic pc_en_b, ifid_en_b, ifid_flush_b, idex_en_b, idex_flush_b, exmem_en_b, memwb_en_b;
   logic halted_b, bus_error_b;
   logic [2:0] stall_count_b;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.TIMEOUT(4), .STALL_CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
      .ex_branch_taken(ex_branch_taken), .exmem_mem_access(exmem_mem_access),
      .dmem_ready(dmem_ready), .imem_ready(imem_ready),
      .pc_en(pc_en_a), .ifid_en(ifid_en_a), .ifid_flush(ifid_flush_a), .idex_en(idex_en_a),
      .idex_flush(idex_flush_a), .exmem_en(exmem_en_a), .memwb_en(memwb_en_a),
      .halted(halted_a), .bus_error(bus_error_a), .stall_count(stall_count_a)
   );

   // Timeout disabled, narrow counter: exercises saturation and the no-halt path.
   pipeline_hazard_ctrl #(.TIMEOUT(0), .STALL_CNT_W(3)) dut_b (
      .clk(clk), .rst(rst),
      .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
      .ex_branch_taken(ex_branch_taken), .exmem_mem_access(exmem_mem_access),
      .dmem_ready(dmem_ready), .imem_ready(imem_ready),
      .pc_en(pc_en_b), .ifid_en(ifid_en_b), .ifid_flush(ifid_flush_b), .idex_en(idex_en_b),
      .idex_flush(idex_flush_b), .exmem_en(exmem_en_b), .memwb_en(memwb_en_b),
      .halted(halted_b), .bus_error(bus_error_b), .stall_count(stall_count_b)
   );

   wire [6:0] ctl_a = {pc_en_a, ifid_en_a, ifid_flush_a, idex_en_a, idex_flush_a, exmem_en_a, memwb_en_a};
   wire [6:0] ctl_b = {pc_en_b, ifid_en_b, ifid_flush_b, idex_en_b, idex_flush_b, exmem_en_b, memwb_en_b};

   function automatic vin_t mk(input logic r, input logic mr, input int rd, input int rs1, input int rs2,
                               input logic br, input logic ma, input logic dr, input logic ir);
      vin_t v;
      v.rst = r; v.mr = mr; v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
      v.br = br; v.ma = ma; v.dr = dr; v.ir = ir;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input vin_t v);
      @(negedge clk);
      rst = v.rst; idex_mem_read = v.mr; idex_rd = v.rd; ifid_rs1 = v.rs1; ifid_rs2 = v.rs2;
      ex_branch_taken = v.br; exmem_mem_access = v.ma; dmem_ready = v.dr; imem_ready = v.ir;
      #1;
   endtask

   // One cycle of the controller's rules, from the description of each event.
   function automatic void mdl_step(input mdl_t s, input int to, input int cw, input vin_t i,
                                    output logic [6:0] ctl, output mdl_t n);
      bit lu, dw, tmo;
      longint cap;
      n = s;
      ctl = E_OFF;
      if (!i.rst) begin
         n.phase = 0; n.waited = 0; n.halted = 0; n.berr = 0; n.stalls = 0;
         return;
      end
      if (s.phase == 3) return;
      lu  = i.mr && (i.rd != 0) && (i.rd == i.rs1 || i.rd == i.rs2);
      dw  = i.ma && !i.dr;
      tmo = (to != 0) && (s.waited == to);
      if (dw) ctl = E_OFF;
      else if (i.br) ctl = E_BR;
      else if (lu) ctl = E_LU;
      else if (!i.ir) ctl = E_IM;
      else ctl = E_FLOW;
      if (s.phase == 0) begin
         if (dw) begin n.phase = 1; n.waited = 1; end
         else if (!i.br && !lu && !i.ir) begin n.phase = 2; n.waited = 1; end
      end else if (s.phase == 1) begin
         if (i.dr) begin n.phase = 0; n.waited = 0; end
         else begin
            ctl = E_OFF;
            if (tmo) begin n.phase = 3; n.halted = 1; n.berr = 1; end
            else if (to != 0) n.waited = s.waited + 1;
         end
      end else begin
         if (dw) begin n.phase = 1; n.waited = 1; end
         else if (i.br || i.ir) begin n.phase = 0; n.waited = 0; end
         else if (tmo) begin n.phase = 3; n.halted = 1; n.berr = 1; end
         else if (to != 0) n.waited = s.waited + 1;
      end
      cap = (longint'(1) << cw) - 1;
      if (!ctl[6] && s.stalls < cap) n.stalls = s.stalls + 1;
   endfunction

   vec_t tbl[12];
   vin_t idle, rst0, dwv;
   mdl_t ma_s, mb_s, na_s, nb_s;
   logic [6:0] ea, eb;
   int dr_pct, ir_pct;

   initial begin
      idle = mk(1, 0, 0, 0, 0, 0, 0, 1, 1);
      rst0 = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
      dwv  = mk(1, 0, 0, 0, 0, 0, 1, 0, 1);

      tbl[0]  = '{mk(1, 0, 0, 0, 0, 0, 0, 1, 1), E_FLOW, 0};   // no event
      tbl[1]  = '{mk(1, 1, 5, 3, 5, 0, 0, 1, 1), E_LU,   1};   // load-use on rs2
      tbl[2]  = '{mk(1, 1, 7, 7, 2, 0, 0, 1, 1), E_LU,   1};   // load-use on rs1
      tbl[3]  = '{mk(1, 1, 0, 0, 0, 0, 0, 1, 1), E_FLOW, 0};   // x0 is never a hazard
      tbl[4]  = '{mk(1, 0, 5, 3, 5, 0, 0, 1, 1), E_FLOW, 0};   // not a load
      tbl[5]  = '{mk(1, 1, 5, 3, 5, 1, 0, 1, 1), E_BR,   0};   // branch beats load-use
      tbl[6]  = '{mk(1, 1, 5, 3, 5, 1, 1, 0, 1), E_OFF,  1};   // dmem wait beats everything
      tbl[7]  = '{mk(1, 0, 0, 0, 0, 0, 0, 1, 0), E_IM,   1};   // fetch not ready
      tbl[8]  = '{mk(1, 0, 0, 0, 0, 1, 0, 1, 0), E_BR,   0};   // branch beats imem wait
      tbl[9]  = '{mk(1, 1, 9, 9, 1, 0, 0, 1, 0), E_LU,   1};   // load-use beats imem wait
      tbl[10] = '{mk(1, 0, 0, 0, 0, 0, 1, 1, 1), E_FLOW, 0};   // access completes at once
      tbl[11] = '{mk(0, 1, 5, 3, 5, 0, 0, 1, 1), E_OFF,  0};   // held in reset

      // Power-up reset.
      step(rst0);
      step(rst0);
      chk("reset_ctl", 64'(ctl_a), 64'(E_OFF));
      chk("reset_halted", 64'(halted_a), 0);
      chk("reset_bus_error", 64'(bus_error_a), 0);
      chk("reset_stall_count", 64'(stall_count_a), 0);
      chk("reset_state", 64'(dut.state_q), 64'(RUN));

      // Single-cycle decode from RUN.
      for (int k = 0; k < 12; k++) begin
         step(rst0);
         step(tbl[k].i);
         chk($sformatf("vec%0d_ctl", k), 64'(ctl_a), 64'(tbl[k].exp_ctl));
         @(posedge clk); #1;
         chk($sformatf("vec%0d_stall", k), 64'(stall_count_a), 64'(tbl[k].exp_stall));
      end

      // Data-memory wait of three cycles, then completion.
      step(rst0);
      for (int k = 0; k < 3; k++) begin
         step(dwv);
         chk($sformatf("dwait_c%0d_ctl", k + 1), 64'(ctl_a), 64'(E_OFF));
      end
      step(mk(1, 0, 0, 0, 0, 0, 1, 1, 1));
      chk("dwait_done_ctl", 64'(ctl_a), 64'(E_FLOW));
      step(idle);
      chk("dwait_state", 64'(dut.state_q), 64'(RUN));
      chk("dwait_stall", 64'(stall_count_a), 3);

      // Timeout with TIMEOUT=4: five waiting cycles, then sticky halt.
      step(rst0);
      for (int k = 0; k < 5; k++) begin
         step(dwv);
         chk($sformatf("tmo_c%0d_ctl", k + 1), 64'(ctl_a), 64'(E_OFF));
         if (k == 4) chk("tmo_not_yet", 64'(halted_a), 0);
      end
      step(mk(1, 0, 0, 0, 0, 0, 1, 1, 1));
      chk("tmo_halted", 64'(halted_a), 1);
      chk("tmo_bus_error", 64'(bus_error_a), 1);
      chk("tmo_ctl_after_ready", 64'(ctl_a), 64'(E_OFF));
      step(mk(1, 0, 0, 0, 0, 1, 0, 1, 1));
      chk("tmo_ctl_ignores_branch", 64'(ctl_a), 64'(E_OFF));
      step(idle);
      chk("tmo_stall_frozen", 64'(stall_count_a), 5);
      chk("tmo_halted_sticky", 64'(halted_a), 1);
      step(rst0);
      chk("halt_reset_ctl", 64'(ctl_a), 64'(E_OFF));
      step(idle);
      chk("halt_reset_halted", 64'(halted_a), 0);
      chk("halt_reset_bus_error", 64'(bus_error_a), 0);
      chk("halt_reset_ctl_flow", 64'(ctl_a), 64'(E_FLOW));

      // Fetch wait interrupted by a taken branch.
      step(rst0);
      step(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
      chk("iwait_c1_ctl", 64'(ctl_a), 64'(E_IM));
      step(mk(1, 0, 0, 0, 0, 1, 0, 1, 0));
      chk("iwait_state_c2", 64'(dut.state_q), 64'(IMEM_WAIT));
      chk("iwait_c2_ctl", 64'(ctl_a), 64'(E_BR));
      step(idle);
      chk("iwait_exit_state", 64'(dut.state_q), 64'(RUN));
      chk("iwait_exit_cnt", 64'(dut.wait_cnt_q), 0);

      // Reset in the middle of a data-memory wait.
      step(rst0);
      step(dwv);
      step(dwv);
      step(mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
      chk("rstmid_cnt_before", 64'(dut.wait_cnt_q), 2);
      chk("rstmid_ctl", 64'(ctl_a), 64'(E_OFF));
      step(idle);
      chk("rstmid_state", 64'(dut.state_q), 64'(RUN));
      chk("rstmid_stall", 64'(stall_count_a), 0);
      chk("rstmid_halted", 64'(halted_a), 0);
      chk("rstmid_ctl_flow", 64'(ctl_a), 64'(E_FLOW));
      step(mk(1, 1, 4, 4, 0, 0, 0, 1, 1));
      chk("rstmid_lu_ctl", 64'(ctl_a), 64'(E_LU));
      step(idle);
      chk("rstmid_lu_stall", 64'(stall_count_a), 1);

      // Saturation of a 3-bit counter, timeout disabled.
      step(rst0);
      for (int k = 0; k < 10; k++) step(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
      chk("sat_stall_b", 64'(stall_count_b), 7);
      chk("sat_no_halt_b", 64'(halted_b), 0);
      chk("sat_ctl_b", 64'(ctl_b), 64'(E_IM));

      // Randomised run against the reference model, both parameterisations.
      step(rst0);
      ma_s = '{0, 0, 0, 0, 0};
      mb_s = '{0, 0, 0, 0, 0};
      dr_pct = 60;
      ir_pct = 70;
      for (int c = 0; c < 3000; c++) begin
         vin_t v;
         if (c % 100 == 0) begin
            dr_pct = (c % 300 == 0) ? 10 : ((c % 300 == 100) ? 60 : 90);
            ir_pct = (c % 200 == 0) ? 15 : 85;
         end
         v.rst = ($urandom_range(0, 59) != 0);
         v.mr  = $urandom_range(0, 1);
         v.rd  = 5'($urandom_range(0, 7));
         v.rs1 = 5'($urandom_range(0, 7));
         v.rs2 = 5'($urandom_range(0, 7));
         v.br  = ($urandom_range(0, 3) == 0);
         v.ma  = ($urandom_range(0, 4) < 2);
         v.dr  = ($urandom_range(0, 99) < dr_pct);
         v.ir  = ($urandom_range(0, 99) < ir_pct);
         step(v);
         mdl_step(ma_s, 4, 32, v, ea, na_s);
         mdl_step(mb_s, 0, 3, v, eb, nb_s);
         chk("rnd_ctl_a", 64'(ctl_a), 64'(ea));
         chk("rnd_flags_a", 64'({halted_a, bus_error_a}), 64'({ma_s.halted, ma_s.berr}));
         chk("rnd_stall_a", 64'(stall_count_a), 64'(ma_s.stalls));
         chk("rnd_ctl_b", 64'(ctl_b), 64'(eb));
         chk("rnd_flags_b", 64'({halted_b, bus_error_b}), 64'({mb_s.halted, mb_s.berr}));
         chk("rnd_stall_b", 64'(stall_count_b), 64'(mb_s.stalls));
         ma_s = na_s;
         mb_s = nb_s;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
